// File: rtl/line_burst_adaptor_pkg.sv
// Shared types and default geometry for the line-to-beat burst adaptor.
package line_burst_adaptor_pkg;

    localparam int LINE_W_DEF  = 256;
    localparam int BEAT_W_DEF  = 64;
    localparam int ADDR_W_DEF  = 32;
    localparam int BEATS       = LINE_W_DEF / BEAT_W_DEF;
    localparam int OFFSET_BITS = $clog2(LINE_W_DEF / 8);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD_BURST = 2'd1;
    localparam logic [1:0] ST_WR_BURST = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        RD_BURST = ST_RD_BURST,
        WR_BURST = ST_WR_BURST,
        DONE     = ST_DONE
    } lba_state_e;

    // A single-beat line still needs a one-bit counter to stay legal.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide register addressable per beat, with a full-line load port.
module line_beat_buffer #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              beat_we_i,
    input  logic [IDX_W-1:0]  beat_wr_idx_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic [IDX_W-1:0]  beat_rd_idx_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic [LINE_W-1:0] line_o
);
    localparam int NBEATS = LINE_W / BEAT_W;

    genvar gi;
    generate
        for (gi = 0; gi < NBEATS; gi++) begin : g_beat
            logic [BEAT_W-1:0] beat_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    beat_q <= '0;
                end else if (load_i) begin
                    beat_q <= line_i[gi*BEAT_W +: BEAT_W];
                end else if (beat_we_i && (beat_wr_idx_i == IDX_W'(gi))) begin
                    beat_q <= beat_i;
                end
            end

            assign line_o[gi*BEAT_W +: BEAT_W] = beat_q;
        end
    endgenerate

    assign beat_o = line_o[beat_rd_idx_i*BEAT_W +: BEAT_W];

endmodule

// File: rtl/line_burst_adaptor.sv
// Turns whole-line pmem requests into fixed-length DRAM beat bursts.
// Optional protocol checker enabled by LINE_BURST_ADAPTOR_CHECK_EN.
module line_burst_adaptor
    import line_burst_adaptor_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [ADDR_W-1:0] pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              dram_read,
    output logic              dram_write,
    output logic [ADDR_W-1:0] dram_address,
    output logic [BEAT_W-1:0] dram_wdata,
    input  logic [BEAT_W-1:0] dram_rdata,
    input  logic              dram_resp,
    output logic              proto_err
);
    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int CNT_W  = cnt_width(NBEATS);
    localparam int OFF    = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};

    lba_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wline_load;
    logic              rbeat_we;
    logic [BEAT_W-1:0] wbeat;
    logic [BEAT_W-1:0] rbuf_beat_unused;
    logic [LINE_W-1:0] wbuf_line_unused;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wline_load = 1'b0;
        rbeat_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pmem_read) begin
                    state_d = RD_BURST;
                    addr_d  = pmem_address & ADDR_MASK;
                    cnt_d   = '0;
                end else if (pmem_write) begin
                    state_d    = WR_BURST;
                    addr_d     = pmem_address & ADDR_MASK;
                    cnt_d      = '0;
                    wline_load = 1'b1;
                end
            end
            RD_BURST: begin
                if (dram_resp) begin
                    rbeat_we = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NBEATS - 1)) state_d = DONE;
                end
            end
            WR_BURST: begin
                if (dram_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NBEATS - 1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Separate read and write lines so a write burst never disturbs pmem_rdata.
    line_beat_buffer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .IDX_W(CNT_W)) u_rd_buf (
        .clk           (clk),
        .rst           (rst),
        .load_i        (1'b0),
        .line_i        ('0),
        .beat_we_i     (rbeat_we),
        .beat_wr_idx_i (cnt_q),
        .beat_i        (dram_rdata),
        .beat_rd_idx_i (cnt_q),
        .beat_o        (rbuf_beat_unused),
        .line_o        (pmem_rdata)
    );

    line_beat_buffer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .IDX_W(CNT_W)) u_wr_buf (
        .clk           (clk),
        .rst           (rst),
        .load_i        (wline_load),
        .line_i        (pmem_wdata),
        .beat_we_i     (1'b0),
        .beat_wr_idx_i (cnt_q),
        .beat_i        ('0),
        .beat_rd_idx_i (cnt_q),
        .beat_o        (wbeat),
        .line_o        (wbuf_line_unused)
    );

    assign pmem_resp    = (state_q == DONE);
    assign dram_read    = (state_q == RD_BURST);
    assign dram_write   = (state_q == WR_BURST);
    assign dram_address = addr_q;
    assign dram_wdata   = dram_write ? wbeat : '0;

`ifdef LINE_BURST_ADAPTOR_CHECK_EN
    logic              err_q;
    logic [ADDR_W-1:0] raw_addr_q;
    logic              in_burst;
    logic              viol;

    assign in_burst = (state_q == RD_BURST) || (state_q == WR_BURST);
    assign viol = (pmem_read && pmem_write)
               || ((state_q == RD_BURST) && !pmem_read)
               || ((state_q == WR_BURST) && !pmem_write)
               || (in_burst && (pmem_address != raw_addr_q));

    // Raw address is tracked while idle so the full request address is compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            raw_addr_q <= '0;
        end else begin
            if (state_q == IDLE) raw_addr_q <= pmem_address;
            if (viol) err_q <= 1'b1;
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: directed table, corner sequences, random traffic.
module tb_line_burst_adaptor;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    localparam int NBEATS = LINE_W / BEAT_W;
`ifdef LINE_BURST_ADAPTOR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pmem_read = 1'b0;
    logic              pmem_write = 1'b0;
    logic [ADDR_W-1:0] pmem_address = '0;
    logic [LINE_W-1:0] pmem_wdata = '0;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              dram_read;
    logic              dram_write;
    logic [ADDR_W-1:0] dram_address;
    logic [BEAT_W-1:0] dram_wdata;
    logic [BEAT_W-1:0] dram_rdata = '0;
    logic              dram_resp = 1'b0;
    logic              proto_err;

    line_burst_adaptor #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .dram_read    (dram_read),
        .dram_write   (dram_write),
        .dram_address (dram_address),
        .dram_wdata   (dram_wdata),
        .dram_rdata   (dram_rdata),
        .dram_resp    (dram_resp),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    logic [BEAT_W-1:0] rbeat [NBEATS];
    logic [LINE_W-1:0] last_rline = '0;
    bit                exp_err = 1'b0;

    typedef struct packed {
        bit                rd;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [15:0]       gap;
        logic [ADDR_W-1:0] exp_daddr;
        int                exp_resp;
        bit                chk_rdata;
        logic [LINE_W-1:0] exp_rdata;
    } vec_t;

    vec_t vec [5];

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One cache transfer; expected beat/response timing is derived from the gap list.
    task automatic run_txn(input string tag, input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wdata, input logic [15:0] gap,
                           input logic [ADDR_W-1:0] exp_daddr, output int resp_seen);
        int sched [NBEATS];
        int t;
        int beats;
        logic [LINE_W-1:0] line;
        t = 1;
        for (int k = 0; k < NBEATS; k++) begin
            t += int'(gap[k*4 +: 4]);
            sched[k] = t;
            t++;
        end
        resp_seen = -1;
        beats = 0;
        @(negedge clk);
        check({tag, ".idle_before"}, {dram_read, dram_write, pmem_resp}, 3'b000);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wdata;
        dram_resp    = 1'($urandom_range(0, 1));
        dram_rdata   = {$urandom, $urandom};
        for (int c = 1; c <= t; c++) begin
            @(negedge clk);
            if (pmem_resp && resp_seen < 0) resp_seen = c;
            if (c < t) begin
                check({tag, ".dram_read"}, dram_read, rd);
                check({tag, ".dram_write"}, dram_write, !rd && wr);
                check({tag, ".resp_early"}, pmem_resp, 1'b0);
                check({tag, ".dram_address"}, dram_address, exp_daddr);
                if (!rd) check({tag, ".dram_wdata"}, dram_wdata, wdata[beats*BEAT_W +: BEAT_W]);
                if (beats < NBEATS && c == sched[beats]) begin
                    dram_resp  = 1'b1;
                    dram_rdata = rbeat[beats];
                    beats++;
                end else begin
                    dram_resp  = 1'b0;
                    dram_rdata = {$urandom, $urandom};
                end
            end else begin
                check({tag, ".pmem_resp"}, pmem_resp, 1'b1);
                check({tag, ".dram_idle_done"}, {dram_read, dram_write}, 2'b00);
                if (rd) begin
                    for (int k = 0; k < NBEATS; k++) line[k*BEAT_W +: BEAT_W] = rbeat[k];
                    last_rline = line;
                end
                check({tag, ".pmem_rdata"}, pmem_rdata, last_rline);
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
                dram_resp  = 1'($urandom_range(0, 1));
                dram_rdata = {$urandom, $urandom};
            end
            check({tag, ".proto_err"}, proto_err, exp_err);
        end
    endtask

    initial begin
        int rc;
        logic [LINE_W-1:0] wd;
        logic [ADDR_W-1:0] a;
        logic [15:0] g;
        bit r;

        vec[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234, wdata: '0, gap: 16'h0000,
                   exp_daddr: 32'h0000_1220, exp_resp: 5, chk_rdata: 1'b1,
                   exp_rdata: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vec[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0080,
                   wdata: {64'hD3D3_0000_0000_00D3, 64'hD2D2_0000_0000_00D2,
                           64'hD1D1_0000_0000_00D1, 64'hD0D0_0000_0000_00D0},
                   gap: 16'h0000, exp_daddr: 32'h0000_0080, exp_resp: 5, chk_rdata: 1'b0, exp_rdata: '0};
        vec[2] = '{rd: 1'b1, wr: 1'b0, addr: 32'h4000_0040, wdata: '0, gap: 16'h0300,
                   exp_daddr: 32'h4000_0040, exp_resp: 8, chk_rdata: 1'b0, exp_rdata: '0};
        vec[3] = '{rd: 1'b0, wr: 1'b1, addr: 32'hFFFF_FFFF, wdata: {8{32'hA5A5_5A5A}},
                   gap: 16'h0201, exp_daddr: 32'hFFFF_FFE0, exp_resp: 8, chk_rdata: 1'b0, exp_rdata: '0};
        vec[4] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_001F, wdata: '0, gap: 16'h0002,
                   exp_daddr: 32'h0000_0000, exp_resp: 7, chk_rdata: 1'b0, exp_rdata: '0};

        // Reset values
        @(negedge clk);
        check("reset.pmem", {pmem_resp, pmem_rdata}, '0);
        check("reset.dram", {dram_read, dram_write, dram_address, dram_wdata}, '0);
        check("reset.proto_err", proto_err, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < NBEATS; k++) rbeat[k] = 64'h1111_1111_1111_1111 * 64'(k + 1);
        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("vec%0d", i), vec[i].rd, vec[i].wr, vec[i].addr, vec[i].wdata,
                    vec[i].gap, vec[i].exp_daddr, rc);
            check($sformatf("vec%0d.resp_cycle", i), LINE_W'(rc), LINE_W'(vec[i].exp_resp));
            if (vec[i].chk_rdata) check($sformatf("vec%0d.rdata_const", i), pmem_rdata, vec[i].exp_rdata);
            $display("vec%0d rd=%0b addr=%h resp_cycle=%0d", i, vec[i].rd, vec[i].addr, rc);
        end

        // Read and write together: read wins, checker flags it when built in
        for (int k = 0; k < NBEATS; k++) rbeat[k] = {$urandom, $urandom};
        exp_err = CHK;
        run_txn("both", 1'b1, 1'b1, 32'h0000_0500, {8{32'hDEAD_BEEF}}, 16'h0000, 32'h0000_0500, rc);
        check("both.resp_cycle", LINE_W'(rc), LINE_W'(5));
        $display("both rd+wr resp_cycle=%0d proto_err=%0b", rc, proto_err);

        // Reset after two beats of a read burst
        for (int k = 0; k < NBEATS; k++) rbeat[k] = {$urandom, $urandom};
        @(negedge clk);
        pmem_read = 1'b1;
        pmem_address = 32'h0000_2000;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            dram_resp  = 1'b1;
            dram_rdata = rbeat[c-1];
        end
        @(negedge clk);
        rst = 1'b1;
        pmem_read = 1'b0;
        dram_resp = 1'b0;
        #1;
        check("rst_mid.pmem", {pmem_resp, pmem_rdata}, '0);
        check("rst_mid.dram", {dram_read, dram_write, dram_address, dram_wdata}, '0);
        check("rst_mid.proto_err", proto_err, 1'b0);
        exp_err = 1'b0;
        last_rline = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mid.no_resp", {pmem_resp, dram_read, dram_write}, 3'b000);
        end
        run_txn("after_rst", 1'b1, 1'b0, 32'h0000_2000, '0, 16'h0000, 32'h0000_2000, rc);
        check("after_rst.resp_cycle", LINE_W'(rc), LINE_W'(5));
        $display("reset mid-burst then read resp_cycle=%0d", rc);

        // Back-to-back read then write
        for (int k = 0; k < NBEATS; k++) rbeat[k] = {$urandom, $urandom};
        run_txn("b2b_rd", 1'b1, 1'b0, 32'h0000_3000, '0, 16'h0000, 32'h0000_3000, rc);
        run_txn("b2b_wr", 1'b0, 1'b1, 32'h0000_3040, {8{32'h1234_5678}}, 16'h0000, 32'h0000_3040, rc);
        check("b2b_wr.resp_cycle", LINE_W'(rc), LINE_W'(5));
        $display("back-to-back read/write resp_cycle=%0d", rc);

        // Random traffic against the arithmetic timing model
        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom_range(0, 1));
            a = $urandom;
            for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom;
            for (int k = 0; k < NBEATS; k++) begin
                g[k*4 +: 4] = 4'($urandom_range(0, 2));
                rbeat[k] = {$urandom, $urandom};
            end
            run_txn($sformatf("rnd%0d", i), r, !r, a, wd, g, a & 32'hFFFF_FFE0, rc);
            $display("rnd%0d rd=%0b addr=%h gaps=%h resp_cycle=%0d", i, r, a, g, rc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
